// File: rtl/ft245_fifo_bridge.sv
// FT245-style synchronous-strobe bridge to an FT2232H FIFO port.
// A TX byte stream is buffered in a small circular FIFO and written out with
// nWR_o pulses. RX bytes are read with nRD_o pulses into a single holding
// register that is drained through a valid/ready stream.
module ft245_fifo_bridge #(
  parameter int TX_DEPTH = 16,
  parameter int WR_PULSE = 2,
  parameter int RD_PULSE = 2,
  parameter int RECOVER  = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  inout  wire  [7:0]                  data_io,
  input  logic                        nRXF_i,
  input  logic                        nTXE_i,
  output logic                        nRD_o,
  output logic                        nWR_o,
  input  logic                        tx_valid_i,
  input  logic [7:0]                  tx_data_i,
  output logic                        tx_ready_o,
  output logic                        rx_valid_o,
  output logic [7:0]                  rx_data_o,
  input  logic                        rx_ready_i,
  output logic [$clog2(TX_DEPTH):0]   tx_level_o,
  output logic                        busy_o
);

  localparam int AW   = $clog2(TX_DEPTH);
  localparam int LW   = AW + 1;
  localparam int MAXP = (WR_PULSE > RD_PULSE) ?
                        ((WR_PULSE > RECOVER) ? WR_PULSE : RECOVER) :
                        ((RD_PULSE > RECOVER) ? RD_PULSE : RECOVER);
  localparam int CW   = $clog2(MAXP + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_HOLD, S_RD, S_RECOVER
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_tx_q, last_tx_d;     // last served access was a write
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   tx_level_q, tx_level_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic [7:0]      mem_q [TX_DEPTH];

  logic            push, pop, rd_done, data_oe, start;
  logic            rx_pend, tx_pend;

  assign tx_ready_o = (tx_level_q != LW'(TX_DEPTH));
  assign push       = tx_valid_i && tx_ready_o;
  assign rx_pend    = !nRXF_i && (!rx_valid_q || rx_ready_i);
  assign tx_pend    = !nTXE_i && (tx_level_q != '0);

  assign tx_level_o = tx_level_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign data_io    = data_oe ? mem_q[rd_ptr_q] : 8'hzz;

  // State, counter and arbitration history registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_tx_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_tx_q <= last_tx_d;
    end
  end

  // Next state. The last RECOVER cycle arbitrates exactly like IDLE so that
  // back-to-back accesses spend no extra cycle in IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_tx_d = last_tx_q;
    start     = 1'b0;
    case (state_q)
      S_IDLE: start = 1'b1;
      S_WR: begin
        if (cnt_q == CW'(WR_PULSE - 1)) begin
          state_d = S_WR_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WR_HOLD: begin
        state_d = S_RECOVER;
        cnt_d   = '0;
      end
      S_RD: begin
        if (cnt_q == CW'(RD_PULSE - 1)) begin
          state_d = S_RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RECOVER: begin
        if (cnt_q == CW'(RECOVER - 1)) start = 1'b1;
        else                            cnt_d = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      // When both are pending, alternate; a write last (reset value) favours RX
      if (rx_pend && (!tx_pend || last_tx_q)) begin
        state_d   = S_RD;
        last_tx_d = 1'b0;
      end else if (tx_pend) begin
        state_d   = S_WR;
        last_tx_d = 1'b1;
      end
    end
  end

  // Strobes, bus enable and datapath controls decoded from the current state
  always_comb begin
    nRD_o   = (state_q != S_RD);
    nWR_o   = (state_q != S_WR);
    data_oe = (state_q == S_WR) || (state_q == S_WR_HOLD);
    pop     = (state_q == S_WR_HOLD);
    rd_done = (state_q == S_RD) && (cnt_q == CW'(RD_PULSE - 1));
    busy_o  = (state_q != S_IDLE);
  end

  // TX pointer/level and RX holding register next values
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    tx_level_d = tx_level_q;
    if (push && !pop)      tx_level_d = tx_level_q + LW'(1);
    else if (!push && pop) tx_level_d = tx_level_q - LW'(1);
    // A fresh capture wins over a consume on the same edge
    rx_valid_d = rx_valid_q;
    if (rd_done)         rx_valid_d = 1'b1;
    else if (rx_ready_i) rx_valid_d = 1'b0;
    rx_data_d  = rd_done ? data_io : rx_data_q;
  end

  // Datapath registers; reset drops any buffered or half-captured data
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_level_q <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_level_q <= tx_level_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // TX storage; contents are meaningless once pointers are reset
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= tx_data_i;
  end

endmodule

// File: tb/tb_ft245_fifo_bridge.sv
// Directed bench for ft245_fifo_bridge: default instance plus a second
// instance with short strobes. The FTDI side drives the bus while nRD is low.
module tb_ft245_fifo_bridge;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  wire  [7:0] data_io;
  logic       nrxf, ntxe, nrd, nwr;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, busy;
  logic [7:0] tx_data, rx_data;
  logic [4:0] tx_level;
  logic       tb_drv;
  logic [7:0] tb_bus;

  wire  [7:0] b_data;
  logic       b_nrxf, b_ntxe, b_nrd, b_nwr;
  logic       b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready, b_busy;
  logic [7:0] b_tx_data, b_rx_data;
  logic [4:0] b_level;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  assign data_io = (tb_drv || !nrd) ? tb_bus : 8'hzz;
  assign b_data  = !b_nrd ? 8'h9A : 8'hzz;

  ft245_fifo_bridge u_dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .data_io(data_io),
    .nRXF_i(nrxf), .nTXE_i(ntxe), .nRD_o(nrd), .nWR_o(nwr),
    .tx_valid_i(tx_valid), .tx_data_i(tx_data), .tx_ready_o(tx_ready),
    .rx_valid_o(rx_valid), .rx_data_o(rx_data), .rx_ready_i(rx_ready),
    .tx_level_o(tx_level), .busy_o(busy)
  );

  ft245_fifo_bridge #(.WR_PULSE(1), .RD_PULSE(3), .RECOVER(1)) u_dut2 (
    .clk_i(clk_i), .reset_ni(reset_ni), .data_io(b_data),
    .nRXF_i(b_nrxf), .nTXE_i(b_ntxe), .nRD_o(b_nrd), .nWR_o(b_nwr),
    .tx_valid_i(b_tx_valid), .tx_data_i(b_tx_data), .tx_ready_o(b_tx_ready),
    .rx_valid_o(b_rx_valid), .rx_data_o(b_rx_data), .rx_ready_i(b_rx_ready),
    .tx_level_o(b_level), .busy_o(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int         nw, nr, na, both, first, second, nlow;
  logic       pr, pw;
  int         kind [4];
  logic [7:0] rdpat, wrpat;

  initial begin
    reset_ni = 1'b0; nrxf = 1'b1; ntxe = 1'b1; tx_valid = 1'b0; tx_data = '0;
    rx_ready = 1'b0; tb_drv = 1'b0; tb_bus = '0;
    b_nrxf = 1'b1; b_ntxe = 1'b1; b_tx_valid = 1'b0; b_tx_data = '0; b_rx_ready = 1'b0;
    first = 0; second = 0;

    // reset values appear before any clock edge
    #1;
    chk("rst_nrd", nrd, 1);       chk("rst_nwr", nwr, 1);
    chk("rst_level", tx_level, 0); chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);     chk("rst_rxv", rx_valid, 0);
    chk("rst_rxd", rx_data, 0);
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);

    // single write
    tx_valid = 1'b1; tx_data = 8'hA5;
    @(negedge clk_i); tx_valid = 1'b0;
    chk("t1_level1", tx_level, 1); chk("t1_idle", busy, 0);
    ntxe = 1'b0;
    @(negedge clk_i);
    chk("t1_nwr_a", nwr, 0); chk("t1_dat_a", data_io, 8'hA5);
    chk("t1_busy_a", busy, 1); chk("t1_nrd", nrd, 1);
    @(negedge clk_i);
    chk("t1_nwr_b", nwr, 0); chk("t1_dat_b", data_io, 8'hA5);
    @(negedge clk_i);
    chk("t1_hold_nwr", nwr, 1); chk("t1_hold_dat", data_io, 8'hA5);
    chk("t1_hold_lvl", tx_level, 1);
    @(negedge clk_i);
    chk("t1_level0", tx_level, 0); chk("t1_busy_r1", busy, 1);
    @(negedge clk_i);
    chk("t1_busy_r2", busy, 1);
    @(negedge clk_i);
    chk("t1_busy_end", busy, 0);
    ntxe = 1'b1;

    // fill to full, attempt overflow, drain in order across the wrap
    for (int i = 0; i < 16; i++) begin
      tx_valid = 1'b1; tx_data = 8'(8'h10 + i);
      @(negedge clk_i);
    end
    tx_valid = 1'b0;
    chk("t2_full_lvl", tx_level, 16); chk("t2_not_ready", tx_ready, 0);
    tx_valid = 1'b1; tx_data = 8'hEE;
    @(negedge clk_i); tx_valid = 1'b0;
    chk("t2_no_ovf", tx_level, 16);
    ntxe = 1'b0;
    nw = 0; pw = 1'b1;
    for (int c = 0; c < 120 && nw < 16; c++) begin
      @(negedge clk_i);
      if (!nwr && pw) begin
        chk($sformatf("t2_data%0d", nw), data_io, 32'(8'h10 + nw));
        if (nw == 0) first = c;
        if (nw == 1) second = c;
        nw++;
      end
      pw = nwr;
    end
    chk("t2_writes", nw, 16);
    chk("t2_wr_period", second - first, 5);
    repeat (8) @(negedge clk_i);
    chk("t2_drained", tx_level, 0); chk("t2_idle", busy, 0);
    ntxe = 1'b1;

    // read held under backpressure
    tb_bus = 8'h3C; rx_ready = 1'b0; nrxf = 1'b0;
    @(negedge clk_i);
    chk("t3_nrd_a", nrd, 0); chk("t3_nwr", nwr, 1);
    @(negedge clk_i);
    chk("t3_nrd_b", nrd, 0); chk("t3_rxv_pre", rx_valid, 0);
    @(negedge clk_i);
    chk("t3_nrd_end", nrd, 1); chk("t3_rxv", rx_valid, 1); chk("t3_rxd", rx_data, 8'h3C);
    tb_bus = 8'h55;
    nlow = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (!nrd) nlow++;
    end
    chk("t3_no_extra", nlow, 0); chk("t3_held", rx_data, 8'h3C); chk("t3_rxv_held", rx_valid, 1);
    rx_ready = 1'b1;
    nr = 0; pr = 1'b1;
    for (int c = 0; c < 30 && nr < 2; c++) begin
      @(negedge clk_i);
      if (!nrd && pr) begin
        if (nr == 0) first = c; else second = c;
        nr++;
      end
      pr = nrd;
    end
    chk("t3_reads", nr, 2);
    chk("t3_rd_period", second - first, 4);
    nrxf = 1'b1;
    repeat (8) @(negedge clk_i);
    chk("t3_rxd_new", rx_data, 8'h55); chk("t3_rxv_drained", rx_valid, 0);
    chk("t3_idle", busy, 0);

    // arbitration after reset: RD, WR, RD, WR
    reset_ni = 1'b0;
    @(negedge clk_i); reset_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1; tx_data = 8'(8'hC0 + i);
      @(negedge clk_i);
    end
    tx_valid = 1'b0;
    chk("t4_level4", tx_level, 4);
    nrxf = 1'b0; ntxe = 1'b0;
    na = 0; both = 0; pr = 1'b1; pw = 1'b1;
    for (int c = 0; c < 60 && na < 4; c++) begin
      @(negedge clk_i);
      if (!nrd && !nwr) both++;
      if (!nrd && pr) begin kind[na] = 0; na++; end
      else if (!nwr && pw) begin kind[na] = 1; na++; end
      pr = nrd; pw = nwr;
    end
    nrxf = 1'b1; ntxe = 1'b1;
    chk("t4_count", na, 4);
    chk("t4_first_rd", kind[0], 0); chk("t4_then_wr", kind[1], 1);
    chk("t4_then_rd", kind[2], 0);  chk("t4_then_wr2", kind[3], 1);
    repeat (10) begin
      @(negedge clk_i);
      if (!nrd && !nwr) both++;
    end
    chk("t4_never_both", both, 0);
    chk("t4_level2", tx_level, 2); chk("t4_idle", busy, 0);

    // reset in the middle of a write
    ntxe = 1'b0;
    @(negedge clk_i);
    chk("t5_in_wr", nwr, 0);
    #2; reset_ni = 1'b0; tb_drv = 1'b1; tb_bus = 8'h00;
    #1;
    chk("t5_nwr", nwr, 1); chk("t5_nrd", nrd, 1); chk("t5_bus_z", data_io, 8'h00);
    chk("t5_level", tx_level, 0); chk("t5_busy", busy, 0); chk("t5_ready", tx_ready, 1);
    @(negedge clk_i);
    tb_drv = 1'b0; ntxe = 1'b1; rx_ready = 1'b0; reset_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("t5_post_lvl", tx_level, 0); chk("t5_post_nwr", nwr, 1);

    // short-strobe instance: RD 3 low, 1 idle, WR 1 low, hold, 1 idle, RD
    b_tx_valid = 1'b1; b_tx_data = 8'h77;
    @(negedge clk_i); b_tx_valid = 1'b0;
    b_rx_ready = 1'b1; b_ntxe = 1'b0; b_nrxf = 1'b0;
    rdpat = '0; wrpat = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      rdpat[7-c] = b_nrd; wrpat[7-c] = b_nwr;
    end
    chk("t6_rd_pattern", rdpat, 8'b0001_1110);
    chk("t6_wr_pattern", wrpat, 8'b1111_0111);
    b_nrxf = 1'b1; b_ntxe = 1'b1;
    repeat (6) @(negedge clk_i);
    chk("t6_idle", b_busy, 0); chk("t6_level", b_level, 0);
    chk("t6_rxd", b_rx_data, 8'h9A); chk("t6_rxv", b_rx_valid, 0);
    chk("t6_ready", b_tx_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ft245_fifo_bridge.md
FT245_FIFO_BRIDGE -- requirements
Module: ft245_fifo_bridge

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 16, TX buffer entries; power of two, minimum 2.
REQ-002 SHALL have parameter WR_PULSE, default 2, clk cycles nWR_o is held low per write; minimum 1.
REQ-003 SHALL have parameter RD_PULSE, default 2, clk cycles nRD_o is held low per read; minimum 1.
REQ-004 SHALL have parameter RECOVER, default 2, idle clk cycles after every access; minimum 1.
REQ-005 SHALL have port clk_i, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port data_io, inout, 8 bits: FT2232H data bus.
REQ-008 SHALL have ports nRXF_i and nTXE_i, input, 1 bit each: FT2232H RX-data-available and TX-space-available, both active-low.
REQ-009 SHALL have ports nRD_o and nWR_o, output, 1 bit each: FT2232H read and write strobes, both active-low.
REQ-010 SHALL have TX stream ports: tx_valid_i (in, 1), tx_data_i (in, 8), tx_ready_o (out, 1).
REQ-011 SHALL have RX stream ports: rx_valid_o (out, 1), rx_data_o (out, 8), rx_ready_i (in, 1).
REQ-012 SHALL have port tx_level_o, output, $clog2(TX_DEPTH)+1 bits: TX buffer occupancy.
REQ-013 SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.

Function
REQ-014 SHALL accept a TX byte into a circular buffer on every edge where tx_valid_i and tx_ready_o are both high; tx_ready_o = (tx_level_o < TX_DEPTH).
REQ-015 SHALL wrap TX read and write pointers modulo TX_DEPTH; a simultaneous push and pop leaves tx_level_o unchanged.
REQ-016 SHALL have RX holding register: rx_valid_o set when a read completes, cleared on an edge with rx_ready_i high.
REQ-017 SHALL hold rx_data_o stable while rx_valid_o is high.
REQ-018 SHALL treat RX as pending when nRXF_i is low and either rx_valid_o is low or rx_ready_i is high.
REQ-019 SHALL treat TX as pending when nTXE_i is low and tx_level_o is nonzero.
REQ-020 SHALL have states IDLE, WR, WR_HOLD, RD and RECOVER.
REQ-021 SHALL, in IDLE, start a transfer on pending requests:
- only one pending: go to that access (TX -> WR, RX -> RD);
- both pending: serve the opposite of the last served; RX wins first after reset.
REQ-022 SHALL, in WR:
- drive data_io with the buffer head;
- hold nWR_o low for exactly WR_PULSE cycles;
- then go to WR_HOLD.
REQ-023 SHALL, in WR_HOLD:
- drive nWR_o high;
- keep data_io driven for 1 cycle;
- pop the buffer head;
- go to RECOVER.
REQ-024 SHALL, in RD:
- hold nRD_o low for exactly RD_PULSE cycles, with data_io high-Z;
- capture data_io into rx_data_o on the edge that ends the last low cycle;
- set rx_valid_o on that same edge;
- go to RECOVER.
REQ-025 SHALL, in RECOVER, keep both strobes high and data_io high-Z for RECOVER cycles, then go to IDLE.
REQ-026 SHALL drive data_io only in WR and WR_HOLD, and high-Z in every other state.
REQ-027 SHALL never assert nRD_o and nWR_o low in the same cycle.
REQ-028 SHALL complete an access once started, ignoring changes on nTXE_i or nRXF_i mid-access.
REQ-029 SHALL give back-to-back writes a period of WR_PULSE+1+RECOVER cycles (default 5), and reads a period of RD_PULSE+RECOVER (default 4).

Reset
REQ-030 SHALL, while reset_ni is low, immediately force the following regardless of clk_i:
- nRD_o=1, nWR_o=1, data_io high-Z;
- rx_valid_o=0, rx_data_o=0, tx_level_o=0, tx_ready_o=1, busy_o=0;
- state IDLE, pointers 0, last-served=TX.
REQ-031 SHALL abandon any access interrupted by reset: no TX pop, no RX capture, no buffered data retained.

Verification
REQ-032 SHALL verify single write: push 0xA5, nTXE_i=0 -> nWR_o low 2 cycles with data_io=0xA5, driven 1 more cycle, tx_level_o 1->0, busy_o high 5 cycles.
REQ-033 SHALL verify fill and wrap: nTXE_i=1, push 17 bytes -> tx_ready_o=0 after 16; release nTXE_i -> 16 bytes written in push order, tx_level_o reaches 0.
REQ-034 SHALL verify read with backpressure: nRXF_i=0, bus=0x3C, rx_ready_i=0 -> one read, rx_data_o=0x3C held; no further nRD_o pulse until rx_ready_i=1.
REQ-035 SHALL verify arbitration: both pending continuously -> strobes alternate RD, WR, RD, WR; never both low.
REQ-036 SHALL verify reset mid-access: reset_ni low during WR -> nWR_o=1 and data_io high-Z without a clock edge, tx_level_o=0.
REQ-037 SHALL verify parameters: WR_PULSE=1, RD_PULSE=3, RECOVER=1 -> nWR_o low 1 cycle, nRD_o low 3 cycles, 1 idle cycle between accesses.
